// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Fixed-latency data-memory responder for a pipeline MEM stage. Holds DEPTH
//   32-bit words in flops, so a reset clears the whole array. Each aligned
//   access stalls the pipeline for LAT cycles and then spends one DONE cycle
//   presenting load data. A misaligned request pulses misalignErr, does not
//   stall, and is otherwise dropped.
//
//   Optional feature macro: DMEM_WRITE_BUFFER_EN
//     When defined, a one-entry posted write buffer is added. Aligned stores
//     complete in zero cycles with no stall, and drain to the array at the
//     next edge. A read that hits a valid buffer entry is served from it.
//
// Parameters
//   DEPTH : number of 32-bit words (power of two, 16..4096)
//   LAT   : access latency in cycles (1..15)
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   memRead     in   load request
//   memWrite    in   store request (wins when memRead is also high)
//   addr[31:0]  in   byte address, wraps modulo DEPTH*4
//   wrData[31:0]in   store data
//   rdData[31:0]out  load data, zero unless rdValid
//   rdValid     out  one-cycle load-data pulse
//   memStall    out  pipeline hold while an access is in flight
//   misalignErr out  one-cycle pulse on a misaligned request
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wrData,
    output logic [31:0] rdData,
    output logic        rdValid,
    output logic        memStall,
    output logic        misalignErr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;

    logic [31:0]    mem [DEPTH];

    // Request captured when an aligned access is accepted; the initiator is
    // free to change its inputs during DONE, so DONE works from this copy.
    logic [AW-1:0]  idx_q;
    logic           wr_q;
    logic [31:0]    data_q;
    logic           cap;

    logic           req;
    logic           misaligned;
    logic [AW-1:0]  req_idx;

    logic           mem_we;
    logic [AW-1:0]  mem_widx;
    logic [31:0]    mem_wdata;

    assign req        = memRead | memWrite;
    assign misaligned = (addr[1:0] != 2'b00);
    assign req_idx    = addr[AW+1:2];

`ifdef DMEM_WRITE_BUFFER_EN
    logic           buf_valid;
    logic [AW-1:0]  buf_idx;
    logic [31:0]    buf_data;
    logic           buf_cap;
`endif

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memStall    = 1'b0;
        misalignErr = 1'b0;
        rdValid     = 1'b0;
        rdData      = 32'h0;
        cap         = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = idx_q;
        mem_wdata   = data_q;
`ifdef DMEM_WRITE_BUFFER_EN
        buf_cap     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        misalignErr = 1'b1;
`ifdef DMEM_WRITE_BUFFER_EN
                    end else if (memWrite) begin
                        // Posted store: absorbed by the buffer, no stall.
                        buf_cap = 1'b1;
`endif
                    end else begin
                        memStall = 1'b1;
                        cap      = 1'b1;
                        if (LAT == 1) begin
                            // Single-cycle latency: the store lands at the
                            // edge ending this cycle, straight from inputs.
                            state_d = DONE;
                            if (memWrite) begin
                                mem_we    = 1'b1;
                                mem_widx  = req_idx;
                                mem_wdata = wrData;
                            end
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 4'(LAT - 2);
                        end
                    end
                end
            end

            WAIT: begin
                memStall = 1'b1;
                if (cnt_q == 4'd0) begin
                    // Last stalled cycle: stores commit at its closing edge.
                    state_d = DONE;
                    mem_we  = wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                if (!wr_q) begin
                    rdValid = 1'b1;
                    rdData  = mem[idx_q];
`ifdef DMEM_WRITE_BUFFER_EN
                    if (buf_valid && (buf_idx == idx_q))
                        rdData = buf_data;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, capture registers, memory array
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= 32'h0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'h0;
`ifdef DMEM_WRITE_BUFFER_EN
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                idx_q  <= req_idx;
                wr_q   <= memWrite;
                data_q <= wrData;
            end
            if (mem_we)
                mem[mem_widx] <= mem_wdata;
`ifdef DMEM_WRITE_BUFFER_EN
            // Drain and refill share one edge, so back-to-back stores
            // never stall.
            if (buf_valid)
                mem[buf_idx] <= buf_data;
            buf_valid <= buf_cap;
            if (buf_cap) begin
                buf_idx  <= req_idx;
                buf_data <= wrData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder (DEPTH=256, LAT=2). Directed
//   vectors from a table, hand-written reset/idle sequences, then random
//   traffic checked against a flat word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] addr, wrData;
    logic [31:0] rdData;
    logic        rdValid, memStall, misalignErr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .addr       (addr),
        .wrData     (wrData),
        .rdData     (rdData),
        .rdValid    (rdValid),
        .memStall   (memStall),
        .misalignErr(misalignErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic drop_inputs();
        memRead = 1'b0; memWrite = 1'b0; addr = 32'h0; wrData = 32'h0;
    endtask

    // Called at posedge+1. Runs one request to completion, checking every
    // cycle against the model, and returns at posedge+1 of the next free cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got);
        int  idx;
        logic is_rd;
        idx   = int'(a[9:2]);
        is_rd = rd && !wr;
        got   = 32'h0;
        memRead = rd; memWrite = wr; addr = a; wrData = d;
        if (a[1:0] != 2'b00) begin
            #4;
            chk("misalign_pulse", {31'h0, misalignErr}, 32'h1);
            chk("misalign_nostall", {31'h0, memStall}, 32'h0);
            chk("misalign_novalid", {31'h0, rdValid}, 32'h0);
            @(posedge clk); #1;
            drop_inputs();
            return;
        end
`ifdef DMEM_WRITE_BUFFER_EN
        if (wr) begin
            #4;
            chk("bufwr_nostall", {31'h0, memStall}, 32'h0);
            chk("bufwr_novalid", {31'h0, rdValid}, 32'h0);
            model[idx] = d;
            @(posedge clk); #1;
            drop_inputs();
            return;
        end
`endif
        for (int c = 0; c < LAT; c++) begin
            #4;
            chk("stall_hi", {31'h0, memStall}, 32'h1);
            chk("stall_novalid", {31'h0, rdValid}, 32'h0);
            chk("stall_nomis", {31'h0, misalignErr}, 32'h0);
            @(posedge clk); #1;
        end
        // DONE: inputs must be ignored, so scramble them.
        memRead = 1'($urandom); memWrite = 1'($urandom);
        addr = $urandom; wrData = $urandom;
        #4;
        got = rdData;
        chk("done_stall_lo", {31'h0, memStall}, 32'h0);
        chk("done_valid", {31'h0, rdValid}, {31'h0, is_rd});
        chk("done_data", rdData, is_rd ? model[idx] : 32'h0);
        chk("done_nomis", {31'h0, misalignErr}, 32'h0);
        if (wr) model[idx] = d;
        @(posedge clk); #1;
        drop_inputs();
    endtask

    task automatic idle_check(input string name);
        drop_inputs();
        #4;
        chk(name, {rdData[30:0] | {30'h0, rdValid}, memStall | misalignErr}, 32'h0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] got;
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0055};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'hFFFF_F010, 32'h0,         32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         32'h0};

        rst = 1'b1;
        drop_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("reset_idle");

        // Directed table, issued back to back.
        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, got);
            chk($sformatf("vec%0d_rddata", i), got, vecs[i].exp);
        end
        idle_check("post_table_idle");

        // Reset in the WAIT cycle of a read aborts it and clears memory.
        memRead = 1'b1; addr = 32'h10;
        #4;
        chk("abort_stall_T", {31'h0, memStall}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drop_inputs();
        #4;
        chk("abort_stall_lo", {31'h0, memStall}, 32'h0);
        chk("abort_novalid", {31'h0, rdValid}, 32'h0);
        @(posedge clk); #1;
        clear_model();
        access(1'b1, 1'b0, 32'h10, 32'h0, got);
        chk("abort_read_zero", got, 32'h0);
        access(1'b1, 1'b0, 32'h400, 32'h0, got);
        chk("abort_read_zero2", got, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic        r, w;
            logic [31:0] a;
            r = 1'($urandom);
            w = 1'($urandom);
            a = {22'($urandom), 6'($urandom_range(0, 15)), 2'b00, 2'b00};
            a[9:4] = 6'($urandom);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (!r && !w) idle_check("rand_idle");
            else access(r, w, a, $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; power of two, range 16..4096.
REQ-002 Parameter LAT, default 2: access latency in cycles; range 1..15; LAT=0 is illegal.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 memRead  input  1  MEM-stage load request.
REQ-007 memWrite  input  1  MEM-stage store request.
REQ-008 addr  input  32  byte address.
REQ-009 wrData  input  32  store data.
REQ-010 rdData  output  32  load data; valid only while rdValid=1, 0 otherwise.
REQ-011 rdValid  output  1  one-cycle pulse when load data is presented.
REQ-012 memStall  output  1  holds the pipeline; the initiator keeps memRead, memWrite, addr and wrData stable while memStall=1.
REQ-013 misalignErr  output  1  one-cycle pulse on a request with addr[1:0]!=0.

Function
REQ-014 The block SHALL implement the states IDLE, WAIT and DONE, with a 4-bit latency counter.
REQ-015 Word index SHALL be addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-016 In IDLE, a request SHALL be any cycle with memRead=1 or memWrite=1; with both high, the request SHALL be treated as a write.
REQ-017 A misaligned request in IDLE SHALL pulse misalignErr in the same cycle, combinationally; SHALL leave memory unchanged; SHALL not stall; and SHALL stay in IDLE.
REQ-018 Aligned request presented in cycle T:
- memStall SHALL be 1, combinationally, in cycles T..T+LAT-1.
- memStall SHALL be 0 in cycle T+LAT, the DONE state.
REQ-019 Read: rdValid SHALL be 1 and rdData SHALL equal mem[index] in cycle T+LAT only.
REQ-020 Write (unbuffered): mem[index] SHALL be updated at the clock edge ending cycle T+LAT-1; rdValid SHALL stay 0.
REQ-021 Request inputs SHALL be ignored in DONE; DONE SHALL return to IDLE after one cycle, so a back-to-back request is accepted at T+LAT+1.
REQ-022 LAT=1: IDLE SHALL go directly to DONE, bypassing WAIT.
REQ-023 With no request, all outputs SHALL be 0.

Reset
REQ-024 On rst=1 at a clock edge: state IDLE, counter 0, all memory words 0, write buffer invalid, rdValid=0, rdData=0, misalignErr=0.
REQ-025 memStall SHALL be 0 in the cycle after reset, even if reset occurred mid-access.
REQ-026 rst asserted during WAIT SHALL abort the access: no rdValid pulse and no memory update; any pending buffered write SHALL be discarded.

Configuration
REQ-027 Macro DMEM_WRITE_BUFFER_EN SHALL add a one-entry posted write buffer.
REQ-028 Defined, aligned write in IDLE:
- SHALL be captured into the buffer with memStall=0, in zero cycles.
- The buffer SHALL drain to memory at the following edge.
- A write in the drain cycle SHALL be captured in the same edge the previous entry drains.
REQ-029 Defined, a read whose index matches a valid buffer entry SHALL return the buffered data, not stale memory.
REQ-030 Undefined: no buffer logic SHALL exist and writes SHALL follow REQ-018 and REQ-020.

Verification
REQ-031 LAT=2, write 0xDEADBEEF to 0x10, then read 0x10 -> memStall high 2 cycles per access; rdValid pulse with rdData=0xDEADBEEF at T+2 of the read.
REQ-032 Read addr 0x13 -> misalignErr pulse in the same cycle; memStall=0; rdValid=0; memory unchanged.
REQ-033 DEPTH=256, write 0xA5A5A5A5 to 0x400 -> read of 0x000 returns 0xA5A5A5A5 (wrap).
REQ-034 rst asserted in cycle T+1 of a read -> memStall=0 and rdValid=0 next cycle; a later read of any address returns 0.
REQ-035 DMEM_WRITE_BUFFER_EN, write 0x12345678 to 0x20 then read 0x20 in the next cycle -> write has no stall; read returns 0x12345678.
REQ-036 memRead=memWrite=1, addr 0x8, wrData 0x55 -> treated as write; rdValid stays 0; subsequent read of 0x8 returns 0x55.
